// File: rtl/score_level_tracker.sv
// score_level_tracker: BCD score, line total and level progression for locked-piece line clears
module score_level_tracker #(
   parameter int unsigned LINES_PER_LEVEL = 10,
   parameter int unsigned MAX_LEVEL       = 15
) (
   input  logic        clk_i,
   input  logic        srst_i,
   input  logic        lines_valid_i,
   input  logic [2:0]  lines_i,
   output logic        ready_o,
   output logic [23:0] score_o,
   output logic [3:0]  level_o,
   output logic [15:0] lines_total_o,
   output logic        level_changed_o
);
   typedef enum logic [1:0] {IDLE, ADD, UPDATE} state_t;
   state_t state, state_next;
   logic [2:0]  n_eff, n_q;
   logic [15:0] pts_in, pts_q;
   logic [3:0]  cnt_q;
   logic [8:0]  prog_q, prog_sum;
   logic [16:0] total_sum;
   logic [23:0] bcd_sum;
   logic [4:0]  digit_sum;
   logic        carry, accept, level_up;

   assign n_eff     = lines_i > 3'd4 ? 3'd4 : lines_i;
   assign ready_o   = state == IDLE;
   assign accept    = lines_valid_i && ready_o && n_eff != 3'd0;
   assign pts_in    = n_eff == 3'd1 ? 16'h0040 : n_eff == 3'd2 ? 16'h0100 : n_eff == 3'd3 ? 16'h0300 : 16'h1200;
   assign prog_sum  = prog_q + 9'(n_q);
   assign total_sum = {1'b0, lines_total_o} + 17'(n_q);
   assign level_up  = prog_sum >= 9'(LINES_PER_LEVEL);

   // six-digit decimal ripple adder; a carry out of the top digit means overflow
   always_comb begin
      bcd_sum   = '0;
      digit_sum = '0;
      carry     = 1'b0;
      for (int i = 0; i < 6; i++) begin
         digit_sum = {1'b0, score_o[4*i +: 4]} + {1'b0, i < 4 ? pts_q[4*i +: 4] : 4'h0} + 5'(carry);
         carry = digit_sum > 5'd9;
         bcd_sum[4*i +: 4] = carry ? 4'(digit_sum + 5'd6) : digit_sum[3:0];
      end
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (srst_i) state <= IDLE;
      else        state <= state_next;
   end

   // next state: ADD runs until the multiplier countdown hits zero, UPDATE is a single cycle
   always_comb begin
      state_next = state;
      if (state == IDLE && accept) state_next = ADD;
      else if (state == ADD && cnt_q == 4'd0) state_next = UPDATE;
      else if (state == UPDATE) state_next = IDLE;
   end

   // datapath: capture report, accumulate score, then commit lines and level
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         n_q             <= '0;
         pts_q           <= '0;
         cnt_q           <= '0;
         prog_q          <= '0;
         score_o         <= '0;
         level_o         <= '0;
         lines_total_o   <= '0;
         level_changed_o <= 1'b0;
      end else begin
         level_changed_o <= 1'b0;
         if (state == IDLE && accept) begin
            n_q   <= n_eff;
            pts_q <= pts_in;
            cnt_q <= level_o;
         end
         if (state == ADD) begin
            score_o <= carry ? 24'h999999 : bcd_sum;
            cnt_q   <= cnt_q - 4'd1;
         end
         if (state == UPDATE) begin
            lines_total_o <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
            prog_q        <= level_up ? prog_sum - 9'(LINES_PER_LEVEL) : prog_sum;
            if (level_up && level_o < 4'(MAX_LEVEL)) begin
               level_o         <= level_o + 4'd1;
               level_changed_o <= 1'b1;
            end
         end
      end
   end
endmodule
